// File: rtl/warp_issue_arb_pkg.sv
// Shared GPU package: warp id width derivation and perf counter sizing.
// Kept typedef-free so legacy blocks can import it without collisions.
package warp_issue_arb_pkg;

    localparam int PERF_CTR_BITS = 32;
    localparam int STREAK_BITS   = 8;

    function automatic int nw_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/warp_issue_arb_if.sv
// Issue grant handshake between the warp arbiter and the issue stage.
// The master presents a warp id; the slave accepts it with grant_ready.
interface warp_issue_arb_if #(
    parameter int NUM_WARPS = 4
);
    import warp_issue_arb_pkg::*;

    localparam int NW_WIDTH = nw_width(NUM_WARPS);

    logic                grant_valid;
    logic [NW_WIDTH-1:0] grant_wid;
    logic                grant_ready;

    modport master (
        output grant_valid,
        output grant_wid,
        input  grant_ready
    );

    modport slave (
        input  grant_valid,
        input  grant_wid,
        output grant_ready
    );

endinterface

// File: rtl/warp_issue_arb_rr_pick.sv
// warp_rr_pick: first set bit of mask, scanning circularly from start.
// Purely combinational; valid is low when the mask is empty.
module warp_rr_pick
    import warp_issue_arb_pkg::*;
#(
    parameter  int NUM_WARPS = 4,
    localparam int NW_WIDTH  = nw_width(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0] mask,
    input  logic [NW_WIDTH-1:0]  start,
    output logic [NW_WIDTH-1:0]  index,
    output logic                 valid
);

    int pos;

    // Walk offsets high to low so the nearest set bit wins last.
    always_comb begin
        index = start;
        valid = 1'b0;
        pos   = 0;
        for (int k = NUM_WARPS - 1; k >= 0; k--) begin
            pos = int'(start) + k;
            if (pos >= NUM_WARPS) begin
                pos = pos - NUM_WARPS;
            end
            if (mask[pos]) begin
                index = NW_WIDTH'(pos);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/warp_issue_arb.sv
// Sticky round-robin warp issue arbiter with a registered grant slot.
// Define WARP_ISSUE_ARB_PERF_EN to add idle/stall perf counters.
module warp_issue_arb
    import warp_issue_arb_pkg::*;
#(
    parameter int NUM_WARPS  = 4,
    parameter int STICKY_MAX = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WARPS-1:0]     ready_warps,
    input  logic                     flush,
`ifdef WARP_ISSUE_ARB_PERF_EN
    output logic [PERF_CTR_BITS-1:0] perf_idles,
    output logic [PERF_CTR_BITS-1:0] perf_stalls,
`endif
    warp_issue_arb_if.master         gnt
);

    localparam int NW_WIDTH = nw_width(NUM_WARPS);
    localparam logic [NW_WIDTH-1:0] LAST_ID = NW_WIDTH'(NUM_WARPS - 1);
    localparam logic [STREAK_BITS-1:0] SMAX = STREAK_BITS'(STICKY_MAX);

    logic                   grant_valid_q;
    logic [NW_WIDTH-1:0]    grant_wid_q;
    logic [NW_WIDTH-1:0]    last_wid_q;
    logic [STREAK_BITS-1:0] streak_q;

    logic                   fire;
    logic                   load;
    logic [NW_WIDTH-1:0]    last_eff;
    logic [STREAK_BITS-1:0] streak_eff;
    logic [NW_WIDTH-1:0]    start_wid;
    logic [NW_WIDTH-1:0]    rr_wid;
    logic                   rr_valid;
    logic                   sticky;
    logic [NW_WIDTH-1:0]    pick_wid;

    assign fire = grant_valid_q & gnt.grant_ready;
    assign load = (~grant_valid_q | fire) & ~flush;

    // History as it stands after this cycle's fire; the pick that
    // refills the slot on a fire must see the grant just consumed.
    always_comb begin
        last_eff   = last_wid_q;
        streak_eff = streak_q;
        if (fire) begin
            last_eff = grant_wid_q;
            if (grant_wid_q != last_wid_q) begin
                streak_eff = STREAK_BITS'(1);
            end else if (streak_q < SMAX) begin
                streak_eff = streak_q + STREAK_BITS'(1);
            end
        end
    end

    assign start_wid = (last_eff == LAST_ID) ? '0
                     : last_eff + NW_WIDTH'(1);

    // Zero streak means no grant history yet, so rotation decides.
    assign sticky = (streak_eff != '0)
                  && (streak_eff < SMAX)
                  && ready_warps[last_eff];

    assign pick_wid = sticky ? last_eff : rr_wid;

    warp_rr_pick #(
        .NUM_WARPS (NUM_WARPS)
    ) u_rr_pick (
        .mask  (ready_warps),
        .start (start_wid),
        .index (rr_wid),
        .valid (rr_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_valid_q <= 1'b0;
            grant_wid_q   <= '0;
            last_wid_q    <= LAST_ID;
            streak_q      <= '0;
        end else begin
            last_wid_q <= last_eff;
            streak_q   <= streak_eff;
            if (load) begin
                grant_valid_q <= rr_valid;
                if (rr_valid) begin
                    grant_wid_q <= pick_wid;
                end
            end else if (flush) begin
                grant_valid_q <= 1'b0;
            end
        end
    end

    assign gnt.grant_valid = grant_valid_q;
    assign gnt.grant_wid   = grant_wid_q;

`ifdef WARP_ISSUE_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_idles  <= '0;
            perf_stalls <= '0;
        end else begin
            if (~grant_valid_q) begin
                perf_idles <= perf_idles + PERF_CTR_BITS'(1);
            end
            if (grant_valid_q & ~gnt.grant_ready) begin
                perf_stalls <= perf_stalls + PERF_CTR_BITS'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_warp_issue_arb.sv
// Bench for warp_issue_arb: directed vector table, corner sequences and
// random traffic against a behavioural arbitration model.
module tb_warp_issue_arb;
    import warp_issue_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rdy = 4'h0;
    logic       gr  = 1'b0;
    logic       fl  = 1'b0;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    warp_issue_arb_if #(.NUM_WARPS(4)) i0 ();
    warp_issue_arb_if #(.NUM_WARPS(4)) i1 ();
    warp_issue_arb_if #(.NUM_WARPS(1)) i2 ();

    assign i0.grant_ready = gr;
    assign i1.grant_ready = gr;
    assign i2.grant_ready = gr;

`ifdef WARP_ISSUE_ARB_PERF_EN
    logic [PERF_CTR_BITS-1:0] p0_idl, p0_stl, p1_idl, p1_stl, p2_idl, p2_stl;
`endif

    warp_issue_arb #(.NUM_WARPS(4), .STICKY_MAX(4)) d0 (
        .clk         (clk),
        .reset       (rst),
        .ready_warps (rdy),
        .flush       (fl),
`ifdef WARP_ISSUE_ARB_PERF_EN
        .perf_idles  (p0_idl),
        .perf_stalls (p0_stl),
`endif
        .gnt         (i0)
    );

    warp_issue_arb #(.NUM_WARPS(4), .STICKY_MAX(1)) d1 (
        .clk         (clk),
        .reset       (rst),
        .ready_warps (rdy),
        .flush       (fl),
`ifdef WARP_ISSUE_ARB_PERF_EN
        .perf_idles  (p1_idl),
        .perf_stalls (p1_stl),
`endif
        .gnt         (i1)
    );

    warp_issue_arb #(.NUM_WARPS(1), .STICKY_MAX(4)) d2 (
        .clk         (clk),
        .reset       (rst),
        .ready_warps (rdy[0:0]),
        .flush       (fl),
`ifdef WARP_ISSUE_ARB_PERF_EN
        .perf_idles  (p2_idl),
        .perf_stalls (p2_stl),
`endif
        .gnt         (i2)
    );

    typedef struct {
        int v;
        int w;
        int last;
        int streak;
        int idles;
        int stalls;
    } mdl_t;

    mdl_t m0, m1, m2;

    // Arbitration rules applied one clock at a time on plain integers.
    function automatic int choose(int n, int sm, int r, int last, int st);
        if (st > 0 && st < sm && r[last]) return last;
        for (int k = 1; k <= n; k++) begin
            if (r[(last + k) % n]) return (last + k) % n;
        end
        return -1;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int n, int sm, int r_in,
                                   bit g, bit f, bit rs);
        mdl_t r;
        int   msk;
        bit   fire;
        r = m;
        msk = r_in & ((1 << n) - 1);
        if (rs) begin
            r.v = 0; r.w = 0; r.last = n - 1; r.streak = 0;
            r.idles = 0; r.stalls = 0;
            return r;
        end
        if (m.v == 0) r.idles++;
        else if (!g) r.stalls++;
        fire = (m.v != 0) && g;
        if (fire) begin
            if (m.w == m.last) r.streak = (m.streak < sm) ? m.streak + 1 : sm;
            else r.streak = 1;
            r.last = m.w;
        end
        if (f) r.v = 0;
        else if (m.v == 0 || fire) begin
            if (msk == 0) r.v = 0;
            else begin
                r.v = 1;
                r.w = choose(n, sm, msk, r.last, r.streak);
            end
        end
        return r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic cmp_models();
        chk("d0_valid", int'(i0.grant_valid), m0.v);
        if (m0.v != 0) chk("d0_wid", int'(i0.grant_wid), m0.w);
        chk("d1_valid", int'(i1.grant_valid), m1.v);
        if (m1.v != 0) chk("d1_wid", int'(i1.grant_wid), m1.w);
        chk("d2_valid", int'(i2.grant_valid), m2.v);
        chk("d2_wid_zero", int'(i2.grant_wid), 0);
`ifdef WARP_ISSUE_ARB_PERF_EN
        chk("d0_idles", int'(p0_idl), m0.idles);
        chk("d0_stalls", int'(p0_stl), m0.stalls);
        chk("d1_idles", int'(p1_idl), m1.idles);
        chk("d1_stalls", int'(p1_stl), m1.stalls);
        chk("d2_idles", int'(p2_idl), m2.idles);
        chk("d2_stalls", int'(p2_stl), m2.stalls);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        m0 = mstep(m0, 4, 4, int'(rdy), gr, fl, rst);
        m1 = mstep(m1, 4, 1, int'(rdy), gr, fl, rst);
        m2 = mstep(m2, 1, 4, int'(rdy), gr, fl, rst);
        #1;
        cmp_models();
    endtask

    typedef struct {
        logic [3:0] rdy;
        bit         gr;
        bit         fl;
        bit         rst;
        int         ev;
        int         ew;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic [3:0] r, bit g, bit f, bit rs,
                                int ev, int ew);
        vec_t v;
        v.rdy = r; v.gr = g; v.fl = f; v.rst = rs; v.ev = ev; v.ew = ew;
        tbl.push_back(v);
    endfunction

    initial begin
        // reset, then idle with nothing ready
        add(4'h0, 1, 0, 1, 0, 0);
        repeat (10) add(4'h0, 1, 0, 0, 0, 0);
        // all ready, always accepted: four grants per warp, in order
        for (int k = 0; k < 17; k++) add(4'hF, 1, 0, 0, 1, (k / 4) % 4);
        // warp 1 held through backpressure and ready dropping
        add(4'hA, 1, 0, 0, 1, 1);
        repeat (5) add(4'hA, 0, 0, 0, 1, 1);
        repeat (2) add(4'h0, 0, 0, 0, 1, 1);
        add(4'h0, 1, 0, 0, 0, 0);
        // warp 2 saturates its streak, then rotation wraps to 0
        repeat (6) add(4'h4, 1, 0, 0, 1, 2);
        add(4'h5, 1, 0, 0, 1, 0);
        // flush while firing warp 3 still records the fire
        add(4'h8, 1, 0, 0, 1, 3);
        add(4'h8, 0, 0, 0, 1, 3);
        add(4'hF, 1, 1, 0, 0, 0);
        add(4'h9, 1, 0, 0, 1, 3);
        // reset mid-handshake drops the held grant
        add(4'hF, 0, 0, 0, 1, 3);
        add(4'hF, 1, 0, 1, 0, 0);
        add(4'hF, 1, 0, 0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rdy = tbl[i].rdy;
            gr  = tbl[i].gr;
            fl  = tbl[i].fl;
            rst = tbl[i].rst;
            step();
            chk($sformatf("tbl%0d_valid", i), int'(i0.grant_valid), tbl[i].ev);
            if (tbl[i].ev != 0 || tbl[i].rst)
                chk($sformatf("tbl%0d_wid", i), int'(i0.grant_wid), tbl[i].ew);
`ifdef WARP_ISSUE_ARB_PERF_EN
            if (i == 10) chk("idles_after_10", int'(p0_idl), 10);
`endif
        end

        // STICKY_MAX=1 with only warp 0 ready: rotation falls back to it
        rst = 1; gr = 1; fl = 0; rdy = 4'h0;
        step();
        rst = 0; rdy = 4'h1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("sm1_valid%0d", k), int'(i1.grant_valid), 1);
            chk($sformatf("sm1_wid%0d", k), int'(i1.grant_wid), 0);
        end

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rdy = 4'($urandom_range(0, 15));
            gr  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/warp_issue_arb.md
WARP_ISSUE_ARB -- requirements
Module: warp_issue_arb

Interface
REQ-001 Parameter NUM_WARPS, default 4, number of warps arbitrated; legal range 1..32.
REQ-002 Parameter STICKY_MAX, default 4, max consecutive grants to one warp before forced rotation; legal range 1..255.
REQ-003 clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-004 ready_warps  input  NUM_WARPS  per-warp eligibility (active & ~stalled & ~barrier-stalled).
REQ-005 flush  input  1  drop any held grant.
REQ-006 grant_valid  output  1  grant available.
REQ-007 grant_wid  output  NW_WIDTH  granted warp id, where NW_WIDTH = max(1, clog2(NUM_WARPS)).
REQ-008 grant_ready  input  1  consumer accepts grant; fire = grant_valid & grant_ready.

Function
REQ-009 Outputs SHALL be registered; a ready_warps change affects grant_valid/grant_wid exactly 1 cycle later.
REQ-010 Load slot: a new grant SHALL be loaded when (~grant_valid | fire) & ~flush & (ready_warps != 0).
REQ-011 If the load condition holds with ready_warps == 0, grant_valid SHALL deassert next cycle.
REQ-012 While grant_valid & ~grant_ready & ~flush, grant_valid and grant_wid SHALL hold, even if ready_warps[grant_wid] drops.
REQ-013 Sticky pick: if ready_warps[last_wid] = 1 and streak < STICKY_MAX, the new grant SHALL be last_wid.
REQ-014 Rotate pick: otherwise the new grant SHALL be the first set bit of ready_warps scanning last_wid+1, last_wid+2, ... modulo NUM_WARPS, with last_wid itself checked last.
REQ-015 last_wid SHALL update to grant_wid on each fire.
REQ-016 On fire, streak SHALL increment, saturating at STICKY_MAX, if grant_wid == last_wid; otherwise streak SHALL load 1.
REQ-017 flush SHALL deassert grant_valid next cycle and SHALL block a load that cycle.
REQ-018 flush & fire in the same cycle SHALL count as a fire: last_wid and streak update.
REQ-019 With NUM_WARPS = 1, grant_wid SHALL be constant 0 and stickiness SHALL be irrelevant.

Reset
REQ-020 On reset, grant_valid SHALL be 0, grant_wid 0, last_wid NUM_WARPS-1 (first rotation picks warp 0), streak 0, and perf counters 0.
REQ-021 Reset asserted mid-handshake SHALL discard the held grant without generating a fire.

Configuration
REQ-022 With WARP_ISSUE_ARB_PERF_EN defined, the module SHALL add outputs perf_idles (PERF_CTR_BITS) and perf_stalls (PERF_CTR_BITS).
REQ-023 perf_idles SHALL increment each cycle where ~grant_valid.
REQ-024 perf_stalls SHALL increment each cycle where grant_valid & ~grant_ready.
REQ-025 Both perf counters SHALL wrap.
REQ-026 Without WARP_ISSUE_ARB_PERF_EN, these ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-027 NW_WIDTH derivation and PERF_CTR_BITS SHALL come from the shared GPU package; no new typedefs are required.
REQ-028 Rotating first-set-bit selection SHALL be one sub-module, warp_rr_pick (inputs: mask, start index; outputs: index, valid), with combinational output.

Verification
REQ-029 Reset, ready_warps=4'b0000 -> grant_valid=0 for 10 cycles; with PERF_EN, perf_idles=10.
REQ-030 ready_warps=4'b1111, grant_ready=1, STICKY_MAX=4 -> grant_wid sequence 0,0,0,0,1,1,1,1,2,... one grant per cycle after 1-cycle latency.
REQ-031 ready_warps=4'b1010, grant_ready=0 for 5 cycles, then ready_warps=4'b0000 -> grant_wid=1 held stable; grant_valid stays 1 until grant_ready=1 fires.
REQ-032 After warp 2 fires, ready_warps=4'b0101 -> next grant_wid=0 (rotation from 3 wraps to 0).
REQ-033 Held grant wid=3, flush=1 with grant_ready=1 -> grant_valid=0 next cycle, last_wid=3, streak updated; next grant follows rotation.
REQ-034 STICKY_MAX=1, ready_warps=4'b0001 continuously -> grant_wid=0 every cycle (rotation falls back to last_wid).
